dmem_stall_ctrl: RTL and testbench

Memory-stage data-memory controller for the pipelined RISC-V core. It turns a load or store sitting in the M stage into a req/ack transaction on a multi-cycle data bus. It raises `stall_mem` to the hazard logic until the transaction completes. On loads it returns byte/half/word data, aligned and extended, to the M/W pipeline register; it is the responding end of the pipeline's stall contract.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_stall_ctrl_load_align.sv | 42 ++++
 rtl/dmem_stall_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_stall_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the M-stage data-memory controller.
//   dmem_state_t : controller FSM states (IDLE, REQ, DONE)
//   dmem_size_t  : decoded access width
//   F3_*         : funct3 encodings for loads/stores
//   access_size  : funct3 -> access width (reserved encodings decode as word)
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dmem_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[2] only selects signedness; 011/110/111 fall through to word.
    function automatic dmem_size_t access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_stall_ctrl_load_align.sv
// load_align: combinational load-data extraction and extension.
//   rdata  in  32 : raw word returned by the data bus
//   addr   in  2  : byte offset of the access
//   funct3 in  3  : access size/sign
//   data   out 32 : aligned, sign/zero-extended load result
// Halves use only addr[1]; words ignore addr entirely.
import dmem_pkg::*;

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = '0;
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        case (access_size(funct3))
            SZ_BYTE: data = funct3[2] ? {24'b0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = funct3[2] ? {16'b0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: M-stage data-memory controller. Converts a load/store in M
// into a req/ack bus transaction, stalling the pipeline until it completes.
//   clk, rst (sync, active-high)
//   mem_read_m, mem_write_m, funct3_m, addr_m, write_data_m : M-stage request
//   stall_mem   : hold F/D/X/M, bubble W
//   done_m      : access completes this cycle; load_data_m valid with it
//   misalign_m  : misaligned-access flag (only with DMEM_MISALIGN_TRAP_EN)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb, bus_ack/bus_rdata : data bus
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses instead of issuing them with the low address bits ignored.
import dmem_pkg::*;

module dmem_stall_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] addr_m,
    input  logic [XLEN-1:0] write_data_m,
    output logic            stall_mem,
    output logic [XLEN-1:0] load_data_m,
    output logic            done_m,
    output logic            misalign_m,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    dmem_state_t state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;

    logic        op_m;
    logic        mis;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] aligned;

    assign op_m = mem_read_m | mem_write_m;

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        mis = 1'b0;
        case (access_size(funct3_m))
            SZ_HALF: mis = addr_m[0];
            SZ_WORD: mis = |addr_m[1:0];
            default: mis = 1'b0;
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    // Store lane placement, computed from the live M-stage inputs and
    // captured on the IDLE->REQ edge.
    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = write_data_m;
        case (access_size(funct3_m))
            SZ_BYTE: begin
                wstrb_d = 4'b0001 << addr_m[1:0];
                wdata_d = {4{write_data_m[7:0]}};
            end
            SZ_HALF: begin
                wstrb_d = 4'b0011 << {addr_m[1], 1'b0};
                wdata_d = {2{write_data_m[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = write_data_m;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wstrb_q  <= '0;
            funct3_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_m && !mis) begin
                        we_q     <= mem_write_m;   // store wins over load
                        addr_q   <= addr_m;
                        wdata_q  <= wdata_d;
                        wstrb_q  <= wstrb_d;
                        funct3_q <= funct3_m;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (rdata_q),
        .addr   (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (aligned)
    );

    // A trapped misaligned access completes in IDLE without touching the bus.
    always_comb begin
        stall_mem   = 1'b0;
        done_m      = 1'b0;
        misalign_m  = 1'b0;
        load_data_m = '0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_wstrb   = '0;
        case (state_q)
            ST_IDLE: begin
                stall_mem  = op_m & ~mis;
                done_m     = op_m & mis;
                misalign_m = op_m & mis;
            end
            ST_REQ: begin
                stall_mem = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_wdata = wdata_q;
                bus_wstrb = wstrb_q;
            end
            ST_DONE: begin
                done_m      = 1'b1;
                load_data_m = we_q ? '0 : aligned;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Testbench for dmem_stall_ctrl: directed and randomized accesses checked
// against a transaction-level reference model.
module tb_dmem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [2:0]  funct3_m = '0;
    logic [31:0] addr_m = '0;
    logic [31:0] write_data_m = '0;
    logic        stall_mem;
    logic [31:0] load_data_m;
    logic        done_m;
    logic        misalign_m;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int unsigned checks = 0;
    int unsigned failures = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    dmem_stall_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .addr_m       (addr_m),
        .write_data_m (write_data_m),
        .stall_mem    (stall_mem),
        .load_data_m  (load_data_m),
        .done_m       (done_m),
        .misalign_m   (misalign_m),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int unsigned m_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n = m_bytes(f3);
        if (n == 1) return 4'(1 << (a % 4));
        if (n == 2) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned n = m_bytes(f3);
        if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        int unsigned n = m_bytes(f3);
        logic [31:0] v;
        if (n == 1) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        if (!TRAP) return 1'b0;
        if (m_bytes(f3) == 2) return (a % 2) != 0;
        if (m_bytes(f3) == 4) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Drives one M-stage op and acts as the bus responder. Entered and left
    // 1 time unit after a rising edge.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int unsigned waits,
                              output logic [31:0] got_load, output int unsigned got_stalls);
        int unsigned stalls = 0, reqs = 0, dones = 0, cyc = 0;
        bit mis = m_mis(f3, addr);
        bit fin = 1'b0;
        logic [31:0] e_load = (wr || mis) ? 32'h0 : m_load(f3, addr, rdata);
        logic [31:0] e_wdata = m_wdata(f3, wdata);
        logic [3:0]  e_wstrb = m_wstrb(f3, addr);
        logic [31:0] e_addr = addr & 32'hFFFF_FFFC;
        got_load = 'x;
        mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
        addr_m = addr; write_data_m = wdata;
        while (!fin && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (stall_mem) stalls++;
            if (cyc == 1) begin
                checks++;
                if (bus_req !== 1'b0) begin
                    failures++; $display("FAIL idle_gap: bus_req=%b want 0", bus_req);
                end
            end
            if (bus_req) begin
                reqs++;
                checks++;
                if (bus_addr !== e_addr) begin
                    failures++; $display("FAIL bus_addr: got %h want %h", bus_addr, e_addr);
                end
                checks++;
                if (bus_we !== wr) begin
                    failures++; $display("FAIL bus_we: got %b want %b", bus_we, wr);
                end
                checks++;
                if (bus_wstrb !== e_wstrb) begin
                    failures++; $display("FAIL bus_wstrb: got %b want %b", bus_wstrb, e_wstrb);
                end
                checks++;
                if (bus_wdata !== e_wdata) begin
                    failures++; $display("FAIL bus_wdata: got %h want %h", bus_wdata, e_wdata);
                end
                bus_ack = (reqs > waits);
                bus_rdata = bus_ack ? rdata : $urandom;
            end else begin
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                checks++;
                if (bus_wstrb !== 4'b0000) begin
                    failures++; $display("FAIL wstrb_idle: got %b want 0000", bus_wstrb);
                end
            end
            if (done_m) begin
                dones++;
                fin = 1'b1;
                got_load = load_data_m;
                checks++;
                if (load_data_m !== e_load) begin
                    failures++; $display("FAIL load_data: got %h want %h", load_data_m, e_load);
                end
                checks++;
                if (misalign_m !== mis) begin
                    failures++; $display("FAIL misalign: got %b want %b", misalign_m, mis);
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        got_stalls = stalls;
        checks++;
        if (dones != 1) begin
            failures++; $display("FAIL done_timeout: dones=%0d want 1", dones);
        end
        checks++;
        if (stalls != (mis ? 0 : waits + 2)) begin
            failures++; $display("FAIL stall_count: got %0d want %0d", stalls, mis ? 0 : waits + 2);
        end
        checks++;
        if (reqs != (mis ? 0 : waits + 1)) begin
            failures++; $display("FAIL req_count: got %0d want %0d", reqs, mis ? 0 : waits + 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_mem, done_m, misalign_m, bus_req, bus_we} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000",
                                 {stall_mem, done_m, misalign_m, bus_req, bus_we});
        end
        checks++;
        if ({load_data_m, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            failures++; $display("FAIL reset_data: load=%h addr=%h wdata=%h wstrb=%b want 0",
                                 load_data_m, bus_addr, bus_wdata, bus_wstrb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] ld;
        int unsigned st;
        run_access(1, 0, dmem_pkg::F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, ld, st);
        checks++;
        if (ld !== 32'hDEADBEEF || st != 2) begin
            failures++; $display("FAIL lw_basic: load=%h stalls=%0d want deadbeef/2", ld, st);
        end
        run_access(1, 0, dmem_pkg::F3_LB, 32'h103, 32'h0, 32'h80FF_FFFF, 1, ld, st);
        checks++;
        if (ld !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb_sext: got %h want ffffff80", ld);
        end
        run_access(1, 0, dmem_pkg::F3_LBU, 32'h103, 32'h0, 32'h80FF_FFFF, 0, ld, st);
        checks++;
        if (ld !== 32'h0000_0080) begin
            failures++; $display("FAIL lbu_zext: got %h want 00000080", ld);
        end
        run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, ld, st);
        checks++;
        if (st != 5 || ld !== 32'h0) begin
            failures++; $display("FAIL sh_wait3: stalls=%0d load=%h want 5/0", st, ld);
        end
        run_access(1, 0, dmem_pkg::F3_LHU, 32'h2, 32'h0, 32'h9ABC_1234, 0, ld, st);
        run_access(1, 0, dmem_pkg::F3_LH, 32'h0, 32'h0, 32'h1234_9ABC, 2, ld, st);
        // read and write together: the store is what goes on the bus
        run_access(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h5555_5555, 1, ld, st);
        // reserved funct3 behaves as a word access
        run_access(1, 0, 3'b111, 32'h84, 32'h0, 32'h8765_4321, 0, ld, st);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ld;
        int unsigned st;
        run_access(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 32'h0, 0, ld, st);
        run_access(1, 0, dmem_pkg::F3_LW, 32'h300, 32'h0, 32'h0BAD_F00D, 0, ld, st);
        checks++;
        if (ld !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL b2b_lw: got %h want 0badf00d", ld);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] ld;
        int unsigned st;
        run_access(1, 0, dmem_pkg::F3_LW, 32'h101, 32'h0, 32'h1357_9BDF, 1, ld, st);
        checks++;
        if (ld !== (TRAP ? 32'h0 : 32'h1357_9BDF)) begin
            failures++; $display("FAIL lw_0x101: got %h want %h", ld, TRAP ? 32'h0 : 32'h1357_9BDF);
        end
        @(negedge clk);
        checks++;
        if (misalign_m !== 1'b0 || done_m !== 1'b0) begin
            failures++; $display("FAIL misalign_one_cycle: mis=%b done=%b want 0/0", misalign_m, done_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int unsigned reqs = 0, cyc = 0;
        mem_read_m = 1'b1; funct3_m = dmem_pkg::F3_LW; addr_m = 32'h200;
        bus_ack = 1'b0;
        while (reqs < 2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus_req) reqs++;
        end
        checks++;
        if (reqs != 2) begin
            failures++; $display("FAIL rst_mid_reach: reqs=%0d want 2", reqs);
        end
        rst = 1'b1; mem_read_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({stall_mem, done_m, misalign_m, bus_req, bus_we} !== 5'b0 ||
            {load_data_m, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            failures++; $display("FAIL rst_mid_outputs: req=%b stall=%b addr=%h wstrb=%b want all 0",
                                 bus_req, stall_mem, bus_addr, bus_wstrb);
        end
        bus_ack = 1'b1; bus_rdata = $urandom;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done_m !== 1'b0 || bus_req !== 1'b0) begin
                failures++; $display("FAIL late_ack: done=%b req=%b want 0/0", done_m, bus_req);
            end
        end
        bus_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [31:0] ld;
        int unsigned st;
        logic rd, wr;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            run_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 4), ld, st);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_misalign;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
